// File: rtl/regfile_mp.sv
// Multi-port integer register file with hardwired x0, optional write-to-read bypass,
// and a per-register busy scoreboard. Synchronous reset restores the init values.
module regfile_mp #(
    parameter int unsigned     XLEN    = 32,
    parameter int unsigned     DEPTH   = 32,
    parameter int unsigned     NUM_RD  = 2,
    parameter int unsigned     NUM_WR  = 1,
    parameter int unsigned     BYPASS  = 1,
    parameter int unsigned     SP_IDX  = 2,
    parameter logic [XLEN-1:0] SP_INIT = XLEN'(64),
    localparam int unsigned    AW      = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*XLEN-1:0]   rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*AW-1:0]     wr_addr,
    input  logic [NUM_WR*XLEN-1:0]   wr_data,
    input  logic                     iss_en,
    input  logic [AW-1:0]            iss_addr
);

    if (SP_IDX == 0 || SP_IDX >= DEPTH) begin : g_bad_sp_idx
        $error("regfile_mp: SP_IDX must be in 1..DEPTH-1");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("regfile_mp: DEPTH must be a power of two >= 2");
    end
    if (NUM_WR < 1 || NUM_WR > 4) begin : g_bad_num_wr
        $error("regfile_mp: NUM_WR must be 1..4");
    end

    logic [XLEN-1:0]  regs_q [DEPTH];
    logic [XLEN-1:0]  regs_d [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Later ports overwrite earlier ones, so the highest enabled port index wins.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int unsigned j = 0; j < NUM_WR; j++) begin
            if (wr_en[j] && wr_addr[j*AW +: AW] != '0) begin
                regs_d[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
                busy_d[wr_addr[j*AW +: AW]] = 1'b0;
            end
        end
        // Issue after writeback: a newer producer keeps the register busy.
        if (iss_en && iss_addr != '0) begin
            busy_d[iss_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                regs_q[k] <= (k == SP_IDX) ? SP_INIT : '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            rd_data[i*XLEN +: XLEN] = regs_q[rd_addr[i*AW +: AW]];
            rd_busy[i]              = busy_q[rd_addr[i*AW +: AW]];
            if (BYPASS != 0) begin
                for (int unsigned j = 0; j < NUM_WR; j++) begin
                    if (wr_en[j] && wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW]) begin
                        rd_data[i*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
                        if (!(iss_en && iss_addr == rd_addr[i*AW +: AW])) begin
                            rd_busy[i] = 1'b0;
                        end
                    end
                end
            end
            if (rd_addr[i*AW +: AW] == '0) begin
                rd_data[i*XLEN +: XLEN] = '0;
                rd_busy[i]              = 1'b0;
            end
        end
    end

endmodule
